regfile_cmd_ctrl: RTL and testbench
===================================

REGFILE_CMD_CTRL -- requirements
Module: regfile_cmd_ctrl

Interface
REQ-001: Parameter DATA_width, default 8, SHALL set the width of the data, RX and TX byte paths.
REQ-002: Parameter Address_width, default 4, SHALL set the width of the register-file address.
REQ-003: CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: RST  input  1  SHALL be the reset, synchronous and active-high.
REQ-005: RX_P_DATA  input  DATA_width  SHALL carry a received byte from the UART receiver.
REQ-006: RX_D_VLD  input  1  SHALL be a one-cycle pulse qualifying RX_P_DATA.
REQ-007: RdData  input  DATA_width  SHALL carry read data from the register file.
REQ-008: RdData_valid  input  1  SHALL qualify RdData.
REQ-009: TX_Busy  input  1  SHALL indicate that the UART transmitter cannot accept a byte.
REQ-010: WrEn  output  1  SHALL be the register-file write strobe.
REQ-011: RdEn  output  1  SHALL be the register-file read strobe.
REQ-012: Address  output  Address_width  SHALL be the register-file address.
REQ-013: WrData  output  DATA_width  SHALL be the register-file write data.
REQ-014: TX_P_DATA  output  DATA_width  SHALL be the byte handed to the UART transmitter.
REQ-015: TX_D_VLD  output  1  SHALL be a one-cycle strobe qualifying TX_P_DATA.
REQ-016: Cmd_error  output  1  SHALL pulse for one cycle on an unknown command byte.
REQ-017: Rx_drop  output  1  SHALL pulse for one cycle when an RX byte arrives while the block is busy and cannot accept it.

Function
REQ-018: The FSM SHALL have exactly these states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
REQ-019: In IDLE:
- RX_D_VLD with byte 0xAA SHALL go to WR_ADDR.
- RX_D_VLD with byte 0xBB SHALL go to RD_ADDR.
- Any other byte SHALL pulse Cmd_error on the next cycle and stay in IDLE.
REQ-020: In WR_ADDR, on RX_D_VLD the block SHALL latch RX_P_DATA[Address_width-1:0] into Address, ignore the upper bits, and go to WR_DATA.
REQ-021: In WR_DATA, on RX_D_VLD the block SHALL latch WrData, assert WrEn for exactly one cycle on the following cycle, and return to IDLE.
REQ-022: In RD_ADDR, on RX_D_VLD the block SHALL latch Address, assert RdEn for exactly one cycle on the following cycle, and go to RD_WAIT.
REQ-023: RD_WAIT SHALL last exactly one cycle, the cycle after RdEn.
- RdData_valid=1: capture RdData into TX_P_DATA and go to TX_SEND.
- RdData_valid=0: pulse Cmd_error and return to IDLE.
REQ-024: In TX_SEND, on the first cycle with TX_Busy=0 the block SHALL assert TX_D_VLD for one cycle and return to IDLE.
- While TX_Busy=1 it SHALL hold TX_P_DATA stable and wait indefinitely.
REQ-025: RX_D_VLD received in RD_WAIT or TX_SEND SHALL be discarded and SHALL pulse Rx_drop on the next cycle; state SHALL be unaffected.
REQ-026: WrEn and RdEn SHALL never be asserted in the same cycle; at most one RX byte is consumed per cycle.
REQ-027: Address and WrData SHALL hold their last latched values between transactions.
REQ-028: TX_P_DATA SHALL hold its value after TX_D_VLD until the next capture.
REQ-029: A partial command (e.g. 0xAA then no further bytes) SHALL wait indefinitely; no timeout is required.
REQ-030: All outputs SHALL be registered.

Reset
REQ-031: With RST=1 at a rising CLK edge, the block SHALL enter IDLE and drive WrEn, RdEn, TX_D_VLD, Cmd_error and Rx_drop to 0, and Address, WrData and TX_P_DATA to all zeros.
REQ-032: RST asserted mid-command SHALL abort it: no WrEn, RdEn or TX_D_VLD SHALL be issued for the aborted command after the reset edge.
REQ-033: RX_D_VLD coincident with RST=1 SHALL be ignored.

Verification
REQ-034: Write: RX bytes 0xAA, 0x05, 0x3C -> one-cycle WrEn with Address=4'h5, WrData=8'h3C; FSM back in IDLE.
REQ-035: Read: RX 0xBB, 0x02 -> RdEn pulse with Address=4'h2; RdData=8'h81 with RdData_valid=1 the next cycle; TX_Busy=0 -> TX_D_VLD pulse with TX_P_DATA=8'h81.
REQ-036: TX backpressure: the read of REQ-035 with TX_Busy=1 for 10 cycles -> no TX_D_VLD for those 10 cycles, TX_P_DATA stable at 8'h81, TX_D_VLD on the first cycle after TX_Busy falls.
REQ-037: Bad command: RX 0x55 in IDLE -> Cmd_error one-cycle pulse, no WrEn/RdEn; a following 0xAA, 0x01, 0xFF -> normal write to address 1.
REQ-038: Overrun: RX byte 0x11 during TX_SEND -> Rx_drop pulse, transmitted byte unchanged.
REQ-039: Reset mid-command: RX 0xAA, 0x03, then RST=1 for one cycle, then RX 0x77 -> no WrEn; 0x77 is treated as an unknown command and pulses Cmd_error.

Source files
------------

// File: rtl/regfile_cmd_ctrl_if.sv
// regfile_cmd_ctrl_if: UART byte stream, register-file and transmitter signals of the command controller
interface regfile_cmd_ctrl_if #(
  parameter int DATA_width    = 8,
  parameter int Address_width = 4
);
  logic [DATA_width-1:0]    RX_P_DATA;
  logic                     RX_D_VLD;
  logic [DATA_width-1:0]    RdData;
  logic                     RdData_valid;
  logic                     TX_Busy;
  logic                     WrEn;
  logic                     RdEn;
  logic [Address_width-1:0] Address;
  logic [DATA_width-1:0]    WrData;
  logic [DATA_width-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     Cmd_error;
  logic                     Rx_drop;
  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_valid, TX_Busy,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_error, Rx_drop
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_valid, TX_Busy,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_error, Rx_drop
  );
endinterface

// File: rtl/regfile_cmd_ctrl.sv
// regfile_cmd_ctrl: decodes UART command bytes into register-file writes and reads, returning read data over TX
module regfile_cmd_ctrl #(
  parameter int DATA_width    = 8,
  parameter int Address_width = 4
) (
  input logic               CLK,
  input logic               RST,
  regfile_cmd_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;
  state_t                   state_q, state_d;
  logic                     wr_en_q, wr_en_d, rd_en_q, rd_en_d, tx_vld_q, tx_vld_d;
  logic                     cmd_err_q, cmd_err_d, rx_drop_q, rx_drop_d;
  logic [Address_width-1:0] addr_q, addr_d;
  logic [DATA_width-1:0]    wr_data_q, wr_data_d, tx_data_q, tx_data_d;
  logic                     vld;
  logic [DATA_width-1:0]    b;
  assign vld = bus.RX_D_VLD;
  assign b   = bus.RX_P_DATA;
  // Next state and registered outputs; RD_ADDR holds through the RdEn cycle so RD_WAIT is the cycle the read data returns
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    cmd_err_d = 1'b0;
    rx_drop_d = 1'b0;
    case (state_q)
      IDLE: if (vld) begin
        state_d   = (b == DATA_width'(8'hAA)) ? WR_ADDR : (b == DATA_width'(8'hBB)) ? RD_ADDR : IDLE;
        cmd_err_d = (b != DATA_width'(8'hAA)) && (b != DATA_width'(8'hBB));
      end
      WR_ADDR: if (vld) begin
        addr_d  = b[Address_width-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (vld) begin
        wr_data_d = b;
        wr_en_d   = 1'b1;
        state_d   = IDLE;
      end
      RD_ADDR: if (rd_en_q) begin
        state_d   = RD_WAIT;
        rx_drop_d = vld;
      end else if (vld) begin
        addr_d  = b[Address_width-1:0];
        rd_en_d = 1'b1;
      end
      RD_WAIT: begin
        rx_drop_d = vld;
        cmd_err_d = !bus.RdData_valid;
        tx_data_d = bus.RdData_valid ? bus.RdData : tx_data_q;
        state_d   = bus.RdData_valid ? TX_SEND : IDLE;
      end
      TX_SEND: begin
        rx_drop_d = vld;
        tx_vld_d  = !bus.TX_Busy;
        state_d   = bus.TX_Busy ? TX_SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      rx_drop_q <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
      rx_drop_q <= rx_drop_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
    end
  end
  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.Cmd_error = cmd_err_q;
  assign bus.Rx_drop   = rx_drop_q;
  assign bus.Address   = addr_q;
  assign bus.WrData    = wr_data_q;
  assign bus.TX_P_DATA = tx_data_q;
endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// tb_regfile_cmd_ctrl: directed vector table, backpressure/overrun sequences and random transactions against a transaction-level model
module tb_regfile_cmd_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] m_addr;
  logic [7:0] m_wd, m_tx;
  logic [7:0] mem [16];
  regfile_cmd_ctrl_if #(.DATA_width(8), .Address_width(4)) bus ();
  regfile_cmd_ctrl #(.DATA_width(8), .Address_width(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    logic       r, v;
    logic [7:0] b;
    logic       rv;
    logic [7:0] rd;
    logic       bz;
    logic [4:0] es;
    logic [3:0] ea;
    logic [7:0] ew, et;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask
  // strobes es = {WrEn, RdEn, TX_D_VLD, Cmd_error, Rx_drop}
  task automatic cyc(input logic r, input logic v, input logic [7:0] b, input logic rv,
                     input logic [7:0] rd, input logic bz, input logic [4:0] es, input string nm);
    RST              = r;
    bus.RX_D_VLD     = v;
    bus.RX_P_DATA    = b;
    bus.RdData_valid = rv;
    bus.RdData       = rd;
    bus.TX_Busy      = bz;
    @(posedge CLK);
    #1;
    chk({nm, " strobes"}, {3'b0, bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.Cmd_error, bus.Rx_drop}, {3'b0, es});
    chk({nm, " Address"}, {4'b0, bus.Address}, {4'b0, m_addr});
    chk({nm, " WrData"}, bus.WrData, m_wd);
    chk({nm, " TX_P_DATA"}, bus.TX_P_DATA, m_tx);
  endtask
  initial begin
    logic [7:0] a, d, x;
    logic       v, ov;
    int         n;
    RST = 1'b1;
    bus.RX_D_VLD = 1'b0;
    bus.RX_P_DATA = '0;
    bus.RdData_valid = 1'b0;
    bus.RdData = '0;
    bus.TX_Busy = 1'b0;
    tbl.push_back('{1, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h0, 8'h00, 8'h00});
    tbl.push_back('{1, 1, 8'hBB, 0, 8'h00, 0, 5'b00000, 4'h0, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'hAA, 0, 8'h00, 0, 5'b00000, 4'h0, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h05, 0, 8'h00, 0, 5'b00000, 4'h5, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h3C, 0, 8'h00, 0, 5'b10000, 4'h5, 8'h3C, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h5, 8'h3C, 8'h00});
    tbl.push_back('{0, 1, 8'hBB, 0, 8'h00, 0, 5'b00000, 4'h5, 8'h3C, 8'h00});
    tbl.push_back('{0, 1, 8'h02, 0, 8'h00, 0, 5'b01000, 4'h2, 8'h3C, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h2, 8'h3C, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 1, 8'h81, 0, 5'b00000, 4'h2, 8'h3C, 8'h81});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 5'b00100, 4'h2, 8'h3C, 8'h81});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h2, 8'h3C, 8'h81});
    tbl.push_back('{0, 1, 8'h55, 0, 8'h00, 0, 5'b00010, 4'h2, 8'h3C, 8'h81});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h2, 8'h3C, 8'h81});
    tbl.push_back('{0, 1, 8'hAA, 0, 8'h00, 0, 5'b00000, 4'h2, 8'h3C, 8'h81});
    tbl.push_back('{0, 1, 8'h01, 0, 8'h00, 0, 5'b00000, 4'h1, 8'h3C, 8'h81});
    tbl.push_back('{0, 1, 8'hFF, 0, 8'h00, 0, 5'b10000, 4'h1, 8'hFF, 8'h81});
    tbl.push_back('{0, 1, 8'hBB, 0, 8'h00, 0, 5'b00000, 4'h1, 8'hFF, 8'h81});
    tbl.push_back('{0, 1, 8'hF7, 0, 8'h00, 0, 5'b01000, 4'h7, 8'hFF, 8'h81});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h7, 8'hFF, 8'h81});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h99, 0, 5'b00010, 4'h7, 8'hFF, 8'h81});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h7, 8'hFF, 8'h81});
    tbl.push_back('{0, 1, 8'hAA, 0, 8'h00, 0, 5'b00000, 4'h7, 8'hFF, 8'h81});
    tbl.push_back('{0, 1, 8'h03, 0, 8'h00, 0, 5'b00000, 4'h3, 8'hFF, 8'h81});
    tbl.push_back('{1, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h0, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h77, 0, 8'h00, 0, 5'b00010, 4'h0, 8'h00, 8'h00});
    tbl.push_back('{1, 1, 8'hAA, 0, 8'h00, 0, 5'b00000, 4'h0, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h05, 0, 8'h00, 0, 5'b00010, 4'h0, 8'h00, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, 4'h0, 8'h00, 8'h00});
    foreach (tbl[i]) begin
      m_addr = tbl[i].ea;
      m_wd   = tbl[i].ew;
      m_tx   = tbl[i].et;
      cyc(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].rv, tbl[i].rd, tbl[i].bz, tbl[i].es, $sformatf("vec%0d", i));
    end
    cyc(0, 1, 8'hBB, 0, 8'h00, 1, 5'b00000, "bp cmd");
    m_addr = 4'h2;
    cyc(0, 1, 8'h02, 0, 8'h00, 1, 5'b01000, "bp addr");
    cyc(0, 0, 8'h00, 0, 8'h00, 1, 5'b00000, "bp rden");
    m_tx = 8'h81;
    cyc(0, 1, 8'h42, 1, 8'h81, 1, 5'b00001, "bp rdwait drop");
    for (int i = 0; i < 10; i++)
      cyc(0, i == 4, 8'h11, 0, 8'h00, 1, {4'b0000, i == 4}, $sformatf("bp busy%0d", i));
    cyc(0, 0, 8'h00, 0, 8'h00, 0, 5'b00100, "bp send");
    cyc(0, 0, 8'h00, 0, 8'h00, 1, 5'b00000, "bp after");
    foreach (mem[i]) mem[i] = 8'($urandom);
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 8'($urandom);
          d = 8'($urandom);
          cyc(0, 1, 8'hAA, 0, 8'h00, 0, 5'b00000, "rw cmd");
          m_addr = a[3:0];
          cyc(0, 1, a, 0, 8'h00, 0, 5'b00000, "rw addr");
          n = $urandom_range(0, 2);
          for (int g = 0; g < n; g++) cyc(0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, "rw gap");
          m_wd = d;
          mem[a[3:0]] = d;
          cyc(0, 1, d, 0, 8'h00, 0, 5'b10000, "rw data");
        end
        1: begin
          a = 8'($urandom);
          cyc(0, 1, 8'hBB, 0, 8'h00, 0, 5'b00000, "rr cmd");
          m_addr = a[3:0];
          cyc(0, 1, a, 0, 8'h00, 0, 5'b01000, "rr addr");
          cyc(0, 0, 8'h00, 0, 8'h00, 0, 5'b00000, "rr rden");
          v  = ($urandom_range(0, 4) != 0);
          ov = 1'($urandom_range(0, 1));
          if (v) m_tx = mem[a[3:0]];
          cyc(0, ov, 8'($urandom), v, mem[a[3:0]], 1'($urandom_range(0, 1)), {3'b000, !v, ov}, "rr wait");
          if (v) begin
            n = $urandom_range(0, 3);
            for (int g = 0; g < n; g++) begin
              ov = 1'($urandom_range(0, 1));
              cyc(0, ov, 8'($urandom), 0, 8'h00, 1, {4'b0000, ov}, "rr busy");
            end
            cyc(0, 0, 8'h00, 0, 8'h00, 0, 5'b00100, "rr send");
          end
        end
        2: begin
          do x = 8'($urandom); while (x == 8'hAA || x == 8'hBB);
          cyc(0, 1, x, 0, 8'h00, 0, 5'b00010, "rbad");
        end
        default: begin
          cyc(0, 1, 8'hAA, 0, 8'h00, 0, 5'b00000, "rrst cmd");
          m_addr = 4'h0;
          m_wd   = 8'h00;
          m_tx   = 8'h00;
          cyc(1, 1'($urandom_range(0, 1)), 8'($urandom), 0, 8'h00, 0, 5'b00000, "rrst");
        end
      endcase
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
